// File: rtl/uart_tx_port.sv
// uart_tx_port: write-only UART transmit port (8N1, LSB first) for a processor bus.
//
// Optional build macro: UART_TX_FIFO_EN adds a 4-entry FIFO between the write port
// and the shifter. Without it, a write is accepted only while the line is idle.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   wr_en    store strobe, one cycle per store
//   wr_data  byte to transmit, sampled with wr_en
//   tx       registered serial output, idle high
//   ready    a write on this cycle will be accepted
//   busy     a frame is on the line or data is queued
//   status   {6'b0, overrun, busy}
module uart_tx_port #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       ready,
  output logic       busy,
  output logic [7:0] status
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            overrun_q;

  logic            baud_tick;
  logic            push;        // write accepted this cycle
  logic            load_avail;  // a byte is available to start a frame
  logic [7:0]      load_byte;
  logic            start_frame; // shifter loads and START begins at this edge

  assign baud_tick = (baud_q == BaudLast);

  // A new frame may start from IDLE, or straight out of a completing STOP.
  assign start_frame = load_avail &&
                       ((state_q == StIdle) || ((state_q == StStop) && baud_tick));

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] count_q;

  // Registered count only, so a same-cycle pop never frees a slot for a push.
  assign ready      = (count_q != 3'd4);
  assign push       = wr_en && ready;
  assign load_avail = (count_q != 3'd0);
  assign load_byte  = fifo_q[rptr_q];
  assign busy       = (state_q != StIdle) || (count_q != 3'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 2'd1;
      end
      if (start_frame) begin
        rptr_q <= rptr_q + 2'd1;
      end
      unique case ({push, start_frame})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  assign ready      = (state_q == StIdle);
  assign push       = wr_en && ready;
  assign load_avail = push;
  assign load_byte  = wr_data;
  assign busy       = (state_q != StIdle);
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = '0;
        idx_d  = 3'd0;
        if (start_frame) begin
          shift_d = load_byte;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_tick) begin
          baud_d  = '0;
          idx_d   = 3'd0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_tick) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_tick) begin
          baud_d = '0;
          idx_d  = 3'd0;
          if (start_frame) begin
            // Back-to-back frame: no idle bit between STOP and START.
            shift_d = load_byte;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Sticky: a dropped write is remembered until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (wr_en && !ready) begin
      overrun_q <= 1'b1;
    end
  end

  assign tx     = tx_q;
  assign status = {6'b0, overrun_q, busy};

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed self-checking bench for uart_tx_port at CLKS_PER_BIT=4.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_uart_tx_port;

  localparam int unsigned Cpb = 4;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx;
  logic       ready;
  logic       busy;
  logic [7:0] status;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_ovr = 1'b0;

  uart_tx_port #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .tx     (tx),
    .ready  (ready),
    .busy   (busy),
    .status (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line level for frame slot 0..9 of byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Issue one write; returns at the falling edge where the start bit is first visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_data = 8'h00;  // later changes must not reach the frame
`ifdef UART_TX_FIFO_EN
    check_eq("fifo_queued_busy", {31'd0, busy}, 32'd1);
    check_eq("fifo_queued_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
`endif
  endtask

  // Check ncyc cycles of a frame; optionally strobe a write at cycle inj.
  task automatic expect_frame(input logic [7:0] b, input int ncyc, input int inj,
                              input logic [7:0] inj_data);
    for (int i = 0; i < ncyc; i++) begin
      check_eq($sformatf("frame_%02h_tx_c%0d", b, i), {31'd0, tx},
               {31'd0, frame_bit(b, i / Cpb)});
      check_eq($sformatf("frame_%02h_status_c%0d", b, i), {24'd0, status},
               {24'd0, 6'b0, exp_ovr, 1'b1});
      if (i == inj) begin
        wr_en   = 1'b1;
        wr_data = inj_data;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (i == inj) exp_ovr = 1'b1;
    end
    wr_en = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_tx"}, {31'd0, tx}, 32'd1);
    check_eq({tag, "_status"}, {24'd0, status}, {24'd0, 6'b0, exp_ovr, 1'b0});
    check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_status", {24'd0, status}, 32'h00);

    // 0x55 frame
    send(8'h55);
    expect_frame(8'h55, 40, -1, 8'h00);
    expect_idle("after_55");

`ifndef UART_TX_FIFO_EN
    // Write during a frame is dropped and sets overrun
    send(8'hA3);
    expect_frame(8'hA3, 40, 10, 8'h11);
    expect_idle("after_a3");
    check_eq("a3_status_after", {24'd0, status}, 32'h02);
    repeat (8) begin
      @(negedge clk);
      check_eq("a3_no_second_frame", {31'd0, tx}, 32'd1);
    end
`endif

    // wr_data changed right after acceptance
    send(8'h80);
    expect_frame(8'h80, 40, -1, 8'h00);
    expect_idle("after_80");

`ifdef UART_TX_FIFO_EN
    // Six consecutive writes: five framed back-to-back, the sixth dropped
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h01;
    for (int t = 0; t < 206; t++) begin
      logic exp_tx;
      @(negedge clk);
      if (t == 0 || t > 200) begin
        exp_tx = 1'b1;
      end else begin
        exp_tx = frame_bit(8'((t - 1) / 40 + 1), ((t - 1) % 40) / Cpb);
      end
      check_eq($sformatf("fifo_tx_t%0d", t), {31'd0, tx}, {31'd0, exp_tx});
      if (t < 5) begin
        wr_data = 8'(t + 2);
      end else begin
        wr_en = 1'b0;
      end
    end
    exp_ovr = 1'b1;
    check_eq("fifo_status_after", {24'd0, status}, 32'h02);
`endif

    // Reset mid-frame, with wr_en held during reset
    send(8'hFF);
    expect_frame(8'hFF, 17, -1, 8'h00);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    @(negedge clk);
    exp_ovr = 1'b0;
    check_eq("midrst_tx", {31'd0, tx}, 32'd1);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_status", {24'd0, status}, 32'h00);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 44; i++) begin
      check_eq($sformatf("postrst_tx_c%0d", i), {31'd0, tx}, 32'd1);
      check_eq($sformatf("postrst_status_c%0d", i), {24'd0, status}, 32'h00);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
